axi_lite_protocol_checker: RTL and testbench

Passive AXI4-Lite bus monitor, instantiated in the verification environment alongside the master/slave pair and wired to the same five channels. It never drives the bus. It checks the handshake rules from the observing end, counts completed transactions, and reports violations as sticky per-rule error flags that the bench polls at end of test.

---
 rtl/axi_lite_protocol_checker.sv | 177 +++++++++++++++++
 tb/tb_axi_lite_protocol_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_protocol_checker.sv
// Passive AXI4-Lite monitor. It watches all five channels without driving any
// of them, checks handshake stability, B/R ordering and stall timeouts, and
// counts completed write/read responses.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   AXI_LITE_*      observed AW/W/B/AR/R channel signals (inputs only)
//   CLR_ERR         pulse that clears ERR_FLAGS and ERR_FIRST
//   ERR_FLAGS       sticky violations: [0]AW [1]W [2]B [3]AR [4]R stability,
//                   [5]B without AW/W, [6]R without AR, [7]timeout
//   ERR_ANY         OR of ERR_FLAGS (combinational)
//   ERR_FIRST       {valid, index} of the first flag raised since reset/clear
//   WR_COUNT        completed B handshakes (wraps)
//   RD_COUNT        completed R handshakes (wraps)
module axi_lite_protocol_checker #(
    parameter int unsigned P_ADDR_WIDTH = 32,
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_CNT_WIDTH  = 16,
    parameter int unsigned P_TIMEOUT    = 256
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [P_ADDR_WIDTH-1:0]   AXI_LITE_AWADDR,
    input  logic [1:0]                AXI_LITE_AWPROT,
    input  logic                      AXI_LITE_AWVALID,
    input  logic                      AXI_LITE_AWREADY,
    input  logic [P_DATA_WIDTH-1:0]   AXI_LITE_WDATA,
    input  logic [P_DATA_WIDTH/8-1:0] AXI_LITE_WSTRB,
    input  logic                      AXI_LITE_WVALID,
    input  logic                      AXI_LITE_WREADY,
    input  logic [1:0]                AXI_LITE_BRESP,
    input  logic                      AXI_LITE_BVALID,
    input  logic                      AXI_LITE_BREADY,
    input  logic [P_ADDR_WIDTH-1:0]   AXI_LITE_ARADDR,
    input  logic [1:0]                AXI_LITE_ARPROT,
    input  logic                      AXI_LITE_ARVALID,
    input  logic                      AXI_LITE_ARREADY,
    input  logic [P_DATA_WIDTH-1:0]   AXI_LITE_RDATA,
    input  logic [1:0]                AXI_LITE_RRESP,
    input  logic                      AXI_LITE_RVALID,
    input  logic                      AXI_LITE_RREADY,
    input  logic                      CLR_ERR,
    output logic [7:0]                ERR_FLAGS,
    output logic                      ERR_ANY,
    output logic [3:0]                ERR_FIRST,
    output logic [P_CNT_WIDTH-1:0]    WR_COUNT,
    output logic [P_CNT_WIDTH-1:0]    RD_COUNT
);

    localparam int unsigned NCH    = 5;
    localparam int unsigned STRB_W = P_DATA_WIDTH / 8;
    localparam int unsigned A_PW   = P_ADDR_WIDTH + 2;
    localparam int unsigned W_PW   = P_DATA_WIDTH + STRB_W;
    localparam int unsigned R_PW   = P_DATA_WIDTH + 2;
    localparam int unsigned PW_AW  = (A_PW > W_PW) ? A_PW : W_PW;
    localparam int unsigned PW     = (PW_AW > R_PW) ? PW_AW : R_PW;
    localparam int unsigned TW     = (P_TIMEOUT == 0) ? 1 : $clog2(P_TIMEOUT + 1);
    localparam int unsigned TLIM   = (P_TIMEOUT == 0) ? 0 : P_TIMEOUT - 1;

    // Channel order used by all per-channel arrays: AW, W, B, AR, R.
    logic [NCH-1:0]     vld, rdy, hs;
    logic [PW-1:0]      pl      [NCH];

    logic [NCH-1:0]     pend_q, pend_d;
    logic [PW-1:0]      pl_q    [NCH];
    logic [PW-1:0]      pl_d    [NCH];
    logic [TW-1:0]      tmr_q   [NCH];
    logic [TW-1:0]      tmr_d   [NCH];
    logic [3:0]         aw_q, aw_d, w_q, w_d, ar_q, ar_d;
    logic [7:0]         flags_q, flags_d, flags_base, viol, fresh;
    logic [3:0]         first_q, first_d;
    logic [P_CNT_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;

    // Saturating outstanding counter; simultaneous +1/-1 cancels out.
    function automatic logic [3:0] outst_upd(input logic [3:0] cnt,
                                             input logic inc,
                                             input logic dec);
        logic [3:0] res;
        res = cnt;
        if (inc && !dec && cnt != 4'hF) res = cnt + 4'd1;
        if (dec && !inc && cnt != 4'h0) res = cnt - 4'd1;
        return res;
    endfunction

    // Gather channels into uniform arrays.
    always_comb begin
        vld   = {AXI_LITE_RVALID, AXI_LITE_ARVALID, AXI_LITE_BVALID,
                 AXI_LITE_WVALID, AXI_LITE_AWVALID};
        rdy   = {AXI_LITE_RREADY, AXI_LITE_ARREADY, AXI_LITE_BREADY,
                 AXI_LITE_WREADY, AXI_LITE_AWREADY};
        hs    = vld & rdy;
        pl[0] = PW'({AXI_LITE_AWADDR, AXI_LITE_AWPROT});
        pl[1] = PW'({AXI_LITE_WDATA, AXI_LITE_WSTRB});
        pl[2] = PW'(AXI_LITE_BRESP);
        pl[3] = PW'({AXI_LITE_ARADDR, AXI_LITE_ARPROT});
        pl[4] = PW'({AXI_LITE_RDATA, AXI_LITE_RRESP});
    end

    // Rule evaluation and next-state computation.
    always_comb begin
        viol   = 8'h00;
        pend_d = vld & ~rdy;
        for (int i = 0; i < NCH; i++) begin
            pl_d[i] = pend_d[i] ? pl[i] : pl_q[i];
            // A stalled channel must keep VALID and its payload next cycle.
            if (pend_q[i] && (!vld[i] || pl[i] != pl_q[i])) viol[i] = 1'b1;
            if (P_TIMEOUT == 0 || !pend_d[i]) begin
                tmr_d[i] = '0;
            end else if (tmr_q[i] >= TW'(TLIM)) begin
                tmr_d[i] = TW'(P_TIMEOUT);
                viol[7]  = 1'b1;
            end else begin
                tmr_d[i] = tmr_q[i] + TW'(1);
            end
        end

        // Ordering checks use pre-update outstanding counts.
        viol[5] = AXI_LITE_BVALID & ((aw_q == 4'h0) | (w_q == 4'h0));
        viol[6] = AXI_LITE_RVALID & (ar_q == 4'h0);

        aw_d = outst_upd(aw_q, hs[0], hs[2]);
        w_d  = outst_upd(w_q,  hs[1], hs[2]);
        ar_d = outst_upd(ar_q, hs[3], hs[4]);

        // A clear and a new violation in the same cycle: the violation wins.
        flags_base = CLR_ERR ? 8'h00 : flags_q;
        flags_d    = flags_base | viol;
        first_d    = CLR_ERR ? 4'h0 : first_q;
        fresh      = viol & ~flags_base;
        if (!first_d[3]) begin
            // Descending scan so the lowest newly set index is kept.
            for (int b = 7; b >= 0; b--) begin
                if (fresh[b]) first_d = {1'b1, 3'(b)};
            end
        end

        wr_d = wr_q + P_CNT_WIDTH'(hs[2]);
        rd_d = rd_q + P_CNT_WIDTH'(hs[4]);
    end

    // State registers; reset also discards any captured pending transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q  <= '0;
            aw_q    <= 4'h0;
            w_q     <= 4'h0;
            ar_q    <= 4'h0;
            flags_q <= 8'h00;
            first_q <= 4'h0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                pl_q[i]  <= '0;
                tmr_q[i] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            aw_q    <= aw_d;
            w_q     <= w_d;
            ar_q    <= ar_d;
            flags_q <= flags_d;
            first_q <= first_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            for (int i = 0; i < NCH; i++) begin
                pl_q[i]  <= pl_d[i];
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

    assign ERR_FLAGS = flags_q;
    assign ERR_ANY   = |flags_q;
    assign ERR_FIRST = first_q;
    assign WR_COUNT  = wr_q;
    assign RD_COUNT  = rd_q;

endmodule

// File: tb/tb_axi_lite_protocol_checker.sv
// Bench for axi_lite_protocol_checker: directed scenarios followed by random
// traffic, every cycle compared against a rule-level reference model.
module tb_axi_lite_protocol_checker;

    localparam int TO = 8;
    localparam int CW = 4;

    logic        CLK = 1'b0;
    logic        RST, CLR_ERR;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [1:0]  AWPROT, ARPROT, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [7:0]  ERR_FLAGS;
    logic        ERR_ANY;
    logic [3:0]  ERR_FIRST;
    logic [CW-1:0] WR_COUNT, RD_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_stall [5];
    logic [63:0] m_pl    [5];
    int          m_len   [5];
    int          m_aw, m_w, m_ar, m_wr, m_rd;
    logic [7:0]  m_flags;
    logic [3:0]  m_first;

    axi_lite_protocol_checker #(
        .P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_CNT_WIDTH(CW), .P_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .AXI_LITE_AWADDR(AWADDR), .AXI_LITE_AWPROT(AWPROT),
        .AXI_LITE_AWVALID(AWVALID), .AXI_LITE_AWREADY(AWREADY),
        .AXI_LITE_WDATA(WDATA), .AXI_LITE_WSTRB(WSTRB),
        .AXI_LITE_WVALID(WVALID), .AXI_LITE_WREADY(WREADY),
        .AXI_LITE_BRESP(BRESP), .AXI_LITE_BVALID(BVALID), .AXI_LITE_BREADY(BREADY),
        .AXI_LITE_ARADDR(ARADDR), .AXI_LITE_ARPROT(ARPROT),
        .AXI_LITE_ARVALID(ARVALID), .AXI_LITE_ARREADY(ARREADY),
        .AXI_LITE_RDATA(RDATA), .AXI_LITE_RRESP(RRESP),
        .AXI_LITE_RVALID(RVALID), .AXI_LITE_RREADY(RREADY),
        .CLR_ERR(CLR_ERR), .ERR_FLAGS(ERR_FLAGS), .ERR_ANY(ERR_ANY),
        .ERR_FIRST(ERR_FIRST), .WR_COUNT(WR_COUNT), .RD_COUNT(RD_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp15(input int x);
        return (x < 0) ? 0 : ((x > 15) ? 15 : x);
    endfunction

    // Apply the rules to the inputs present in this cycle.
    task automatic model_step();
        logic [4:0]  v, r, hs;
        logic [63:0] p [5];
        logic [7:0]  viol, fresh;
        if (RST) begin
            for (int c = 0; c < 5; c++) begin
                m_stall[c] = 1'b0; m_pl[c] = '0; m_len[c] = 0;
            end
            m_aw = 0; m_w = 0; m_ar = 0; m_wr = 0; m_rd = 0;
            m_flags = 8'h00; m_first = 4'h0;
            return;
        end
        v = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
        r = {RREADY, ARREADY, BREADY, WREADY, AWREADY};
        hs = v & r;
        p[0] = 64'({AWADDR, AWPROT});
        p[1] = 64'({WDATA, WSTRB});
        p[2] = 64'(BRESP);
        p[3] = 64'({ARADDR, ARPROT});
        p[4] = 64'({RDATA, RRESP});
        viol = 8'h00;
        for (int c = 0; c < 5; c++) begin
            if (m_stall[c] && (!v[c] || p[c] !== m_pl[c])) viol[c] = 1'b1;
            m_len[c] = (v[c] && !r[c]) ? m_len[c] + 1 : 0;
            if (m_len[c] > TO) m_len[c] = TO;
            if (TO != 0 && m_len[c] >= TO) viol[7] = 1'b1;
        end
        viol[5] = BVALID && (m_aw == 0 || m_w == 0);
        viol[6] = RVALID && (m_ar == 0);
        m_aw = clamp15(m_aw + int'(hs[0]) - int'(hs[2]));
        m_w  = clamp15(m_w  + int'(hs[1]) - int'(hs[2]));
        m_ar = clamp15(m_ar + int'(hs[3]) - int'(hs[4]));
        if (CLR_ERR) begin
            m_flags = 8'h00; m_first = 4'h0;
        end
        fresh   = viol & ~m_flags;
        m_flags = m_flags | viol;
        if (!m_first[3]) begin
            for (int b = 7; b >= 0; b--) if (fresh[b]) m_first = 4'(8 + b);
        end
        m_wr = (m_wr + int'(hs[2])) % (1 << CW);
        m_rd = (m_rd + int'(hs[4])) % (1 << CW);
        for (int c = 0; c < 5; c++) begin
            m_stall[c] = v[c] && !r[c];
            m_pl[c]    = p[c];
        end
    endtask

    // One clock: model, edge, then compare all outputs 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("flags", 32'(ERR_FLAGS), 32'(m_flags));
        chk("any",   32'(ERR_ANY),   32'(m_flags != 8'h00));
        chk("first", 32'(ERR_FIRST), 32'(m_first));
        chk("wr",    32'(WR_COUNT),  32'(m_wr));
        chk("rd",    32'(RD_COUNT),  32'(m_rd));
    endtask

    task automatic idle();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; BVALID = 0; BREADY = 0;
        ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; CLR_ERR = 0;
    endtask

    // Random drive for one channel; a stalled channel usually holds legally.
    task automatic rand_chan(input int c, input int rp);
        bit hold;
        case (c)
            0: hold = AWVALID && !AWREADY;
            1: hold = WVALID && !WREADY;
            2: hold = BVALID && !BREADY;
            3: hold = ARVALID && !ARREADY;
            default: hold = RVALID && !RREADY;
        endcase
        if (hold && $urandom_range(0, 99) < 15) hold = 0;
        case (c)
            0: begin
                if (!hold) begin
                    AWVALID = ($urandom_range(0, 99) < 40);
                    AWADDR = 32'($urandom_range(0, 3) << 2); AWPROT = 2'($urandom_range(0, 3));
                end
                AWREADY = ($urandom_range(0, 99) < rp);
            end
            1: begin
                if (!hold) begin
                    WVALID = ($urandom_range(0, 99) < 40);
                    WDATA = 32'($urandom_range(0, 3)); WSTRB = 4'($urandom_range(0, 15));
                end
                WREADY = ($urandom_range(0, 99) < rp);
            end
            2: begin
                if (!hold) begin
                    BVALID = ($urandom_range(0, 99) < 25); BRESP = 2'($urandom_range(0, 3));
                end
                BREADY = ($urandom_range(0, 99) < rp);
            end
            3: begin
                if (!hold) begin
                    ARVALID = ($urandom_range(0, 99) < 40);
                    ARADDR = 32'($urandom_range(0, 3) << 2); ARPROT = 2'($urandom_range(0, 3));
                end
                ARREADY = ($urandom_range(0, 99) < rp);
            end
            default: begin
                if (!hold) begin
                    RVALID = ($urandom_range(0, 99) < 25);
                    RDATA = 32'($urandom_range(0, 3)); RRESP = 2'($urandom_range(0, 3));
                end
                RREADY = ($urandom_range(0, 99) < rp);
            end
        endcase
    endtask

    initial begin
        int rp;
        RST = 1; idle();
        AWADDR = 0; AWPROT = 0; WDATA = 0; WSTRB = 0; BRESP = 0;
        ARADDR = 0; ARPROT = 0; RDATA = 0; RRESP = 0;
        tick(); tick();
        chk("rst_flags", 32'(ERR_FLAGS), 32'h0);
        chk("rst_first", 32'(ERR_FIRST), 32'h0);
        chk("rst_wr", 32'(WR_COUNT), 32'h0);
        RST = 0; tick();

        // Legal write.
        AWVALID = 1; AWREADY = 1; AWADDR = 32'h10;
        WVALID = 1; WREADY = 1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
        tick();
        idle(); BVALID = 1; BREADY = 1; BRESP = 2'b00;
        tick();
        chk("wr1_flags", 32'(ERR_FLAGS), 32'h00);
        chk("wr1_count", 32'(WR_COUNT), 32'h1);
        idle(); tick();

        // AWADDR changes while stalled.
        AWVALID = 1; AWREADY = 0; AWADDR = 32'h10; tick();
        AWADDR = 32'h14; tick();
        chk("aw_unstable_flags", 32'(ERR_FLAGS), 32'h01);
        chk("aw_unstable_first", 32'(ERR_FIRST), 32'h8);
        tick();
        AWREADY = 1; tick();
        idle(); CLR_ERR = 1; tick();
        idle(); WVALID = 1; WREADY = 1; tick();
        idle(); BVALID = 1; BREADY = 1; tick();
        chk("wr2_count", 32'(WR_COUNT), 32'h2);
        idle(); tick();

        // R without a prior AR, then clear.
        RVALID = 1; RREADY = 1; tick();
        chk("r_orphan_flags", 32'(ERR_FLAGS), 32'h40);
        chk("r_orphan_first", 32'(ERR_FIRST), 32'hE);
        idle(); CLR_ERR = 1; tick();
        chk("clr_flags", 32'(ERR_FLAGS), 32'h00);
        chk("clr_first", 32'(ERR_FIRST), 32'h0);
        chk("clr_rd_kept", 32'(RD_COUNT), 32'h1);
        idle(); tick();

        // AR stall reaching the timeout.
        ARVALID = 1; ARREADY = 0; ARADDR = 32'h20;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("to7_flags", 32'(ERR_FLAGS), 32'h00);
            if (k == 8) begin
                chk("to8_flags", 32'(ERR_FLAGS), 32'h80);
                chk("to8_first", 32'(ERR_FIRST), 32'hF);
            end
        end
        ARREADY = 1; tick();
        idle(); RVALID = 1; RREADY = 1; tick();
        idle(); CLR_ERR = 1; tick();
        // AR stall one cycle short of the timeout.
        idle(); ARVALID = 1; ARREADY = 0;
        for (int k = 1; k <= 7; k++) tick();
        ARREADY = 1; tick();
        chk("to7_only_flags", 32'(ERR_FLAGS), 32'h00);
        idle(); RVALID = 1; RREADY = 1; tick();
        chk("to7_only_rd", 32'(RD_COUNT), 32'h3);
        idle(); tick();

        // B after AW but before W.
        AWVALID = 1; AWREADY = 1; tick();
        idle(); BVALID = 1; BREADY = 1; tick();
        chk("b_early_flags", 32'(ERR_FLAGS), 32'h20);
        chk("b_early_first", 32'(ERR_FIRST), 32'hD);
        idle(); tick();
        AWVALID = 1; AWREADY = 1; tick();
        idle(); BVALID = 1; BREADY = 1; CLR_ERR = 1; tick();
        chk("b_early_clr_flags", 32'(ERR_FLAGS), 32'h20);
        chk("b_early_clr_first", 32'(ERR_FIRST), 32'hD);
        idle(); tick();

        // Reset while AW is stalled.
        AWVALID = 1; AWREADY = 0; AWADDR = 32'h30; tick();
        RST = 1; tick(); tick();
        RST = 0; AWVALID = 0; tick();
        chk("rst_mid_flags", 32'(ERR_FLAGS), 32'h00);
        chk("rst_mid_first", 32'(ERR_FIRST), 32'h0);
        chk("rst_mid_wr", 32'(WR_COUNT), 32'h0);
        chk("rst_mid_rd", 32'(RD_COUNT), 32'h0);

        // Random traffic: fast slave, then a mostly-stalling slave.
        for (int n = 0; n < 400; n++) begin
            rp = (n < 200) ? 60 : 10;
            RST = ($urandom_range(0, 99) == 0);
            CLR_ERR = ($urandom_range(0, 29) == 0);
            for (int c = 0; c < 5; c++) rand_chan(c, rp);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
